uart_rx_fifo: RTL

Receive-side buffer sitting directly downstream of the UART core. It drains each completed byte from the receiver's data register and data-ready flag into a FIFO, and pulses the receiver's read-enable to clear that flag. It gives the host a first-word-fall-through pop interface with fill level, a threshold interrupt and a sticky overrun flag. With it, the host can service RX in bursts instead of once per character.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_rx_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths/depths and RX capture FSM encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_WIDTH         = 8;
   localparam int UART_RX_FIFO_DEPTH = 8;

   // Capture FSM: take a byte, pulse the receiver's read-enable, then wait
   // for the receiver to drop its ready flag before looking for the next byte.
   typedef enum logic [1:0] {
      RXF_IDLE     = 2'd0,
      RXF_ACK      = 2'd1,
      RXF_WAIT_CLR = 2'd2
   } rxf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with show-ahead head output, fill level and flush.
// Latency: push visible on o_rd_dat/o_level the cycle after the push edge; pop advances head at the edge.
// Backpressure: push accepted when not full or when a pop frees a slot on the same edge; refused pushes flagged on o_push_drop.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH,
   parameter int DEPTH = UART_RX_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rd_dat,
   output logic             o_rd_vld,
   output logic [AW:0]      o_level,
   output logic             o_push_drop
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;

   logic             w_nonempty;
   logic             w_pop;
   logic             w_space;
   logic             w_push;

   // Flush overrides both directions; a pop on an empty FIFO is ignored.
   assign w_nonempty  = (r_level != '0);
   assign w_pop       = i_pop & w_nonempty & ~i_flush;
   assign w_space     = (r_level != LVL_FULL) | w_pop;
   assign w_push      = i_push & w_space & ~i_flush;
   assign o_push_drop = i_push & ~w_space & ~i_flush;

   assign o_rd_dat = r_mem[r_rd_ptr];
   assign o_rd_vld = w_nonempty;
   assign o_level  = r_level;

   // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy separately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   // Storage is not reset; at full with a same-edge pop the write lands in the slot being vacated.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains completed UART RX bytes into a FIFO and acks the receiver; host pops with show-ahead data.
// Latency: byte seen ready at edge N is in the FIFO after N; read-enable pulses N..N+1; 3 cycles min per byte.
// Backpressure: none toward the receiver -- a byte arriving at a full FIFO is acked, dropped and flagged as overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH,
   parameter int DEPTH = UART_RX_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] uart_rx_data,
   input  logic             uart_rx_ready,
   output logic             uart_rx_read_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [AW:0]      level,
   input  logic [AW:0]      threshold,
   output logic             thr_interpt,
   output logic             overrun,
   input  logic             ovr_clr,
   input  logic             flush
);

   rxf_state_t  r_state;
   logic        r_read_en;
   logic        r_overrun;

   logic        w_capture;
   logic        w_drop;
   logic [AW:0] w_level;

   // A byte is taken only from IDLE, so each ready assertion yields exactly one capture.
   assign w_capture = (r_state == RXF_IDLE) & uart_rx_ready;

   uart_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .i_push      (w_capture),
      .i_push_dat  (uart_rx_data),
      .i_pop       (rd_en),
      .i_flush     (flush),
      .o_rd_dat    (rd_data),
      .o_rd_vld    (rd_valid),
      .o_level     (w_level),
      .o_push_drop (w_drop)
   );

   assign level           = w_level;
   assign uart_rx_read_en = r_read_en;
   assign overrun         = r_overrun;

   // Level never exceeds DEPTH, so a threshold above DEPTH can never fire.
   assign thr_interpt = (threshold != '0) && (w_level >= threshold);

   // Capture FSM with registered read-enable: high only for the cycle spent in ACK.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= RXF_IDLE;
         r_read_en <= 1'b0;
      end else begin
         r_read_en <= 1'b0;
         case (r_state)
            RXF_IDLE: begin
               if (uart_rx_ready) begin
                  r_state   <= RXF_ACK;
                  r_read_en <= 1'b1;
               end
            end
            RXF_ACK: begin
               r_state <= RXF_WAIT_CLR;
            end
            RXF_WAIT_CLR: begin
               if (!uart_rx_ready) r_state <= RXF_IDLE;
            end
            default: begin
               r_state <= RXF_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun; a new drop on the clear edge keeps it set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (ovr_clr) begin
         r_overrun <= 1'b0;
      end
   end

endmodule
